// File: rtl/chain_driver.sv
// chain_driver: host-side serializer for a daisy chain of shift_register blocks.
// A parallel word is accepted on a valid/ready port and shifted out LSB first.
// An update pulse follows the shift. The bits returning from the chain tail are
// captured as readback of the previous chain contents. The chain-facing outputs
// are re-registered on the falling edge, so they only change while clk is low.

`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module chain_driver #(
  parameter int CELL_LEN    = `DATA_LEN,
  parameter int NUM_DEVICES = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [CELL_LEN*NUM_DEVICES-1:0] wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  output logic [CELL_LEN*NUM_DEVICES-1:0] rd_data,
  output logic                            rd_valid,
  output logic                            busy,
  output logic                            chain_data,
  output logic                            chain_enable,
  output logic                            chain_update,
  input  logic                            chain_return
);

  localparam int TOTAL = CELL_LEN * NUM_DEVICES;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [TOTAL-1:0] r_shift;
  logic [TOTAL-1:0] r_rd_sh;
  logic [TOTAL-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_wr_ready;
  logic             r_busy;
  logic             r_chain_data;
  logic             r_chain_enable;
  logic             r_chain_update;
  logic [TOTAL-1:0] w_rd_next;

  // The returning bit enters at the top of the capture register, so the first bit
  // sampled ends up at bit 0 after TOTAL shifts.
  generate
    if (TOTAL > 1) begin : g_rd_wide
      assign w_rd_next = {chain_return, r_rd_sh[TOTAL-1:1]};
    end else begin : g_rd_single
      assign w_rd_next = chain_return;
    end
  endgenerate

  // Transfer FSM: accept, shift TOTAL bits while capturing the return, then update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rd_sh    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_valid && r_wr_ready) begin
            r_shift    <= wr_data;
            r_cnt      <= '0;
            r_state    <= S_SHIFT;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_SHIFT: begin
          // Each edge here is one chain shift edge; chain_return still holds
          // the pre-shift tail bit.
          r_rd_sh <= w_rd_next;
          r_shift <= r_shift >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_rd_data  <= r_rd_sh;
          r_rd_valid <= 1'b1;
          r_wr_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_wr_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Falling-edge stage: chain pins change only while clk is low, so clk&enable stays glitch-free.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_chain_data   <= 1'b0;
      r_chain_enable <= 1'b0;
      r_chain_update <= 1'b0;
    end else begin
      r_chain_enable <= (r_state == S_SHIFT);
      r_chain_update <= (r_state == S_UPDATE);
      r_chain_data   <= (r_state == S_SHIFT) ? r_shift[0] : 1'b0;
    end
  end

  assign wr_ready     = r_wr_ready;
  assign busy         = r_busy;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign chain_data   = r_chain_data;
  assign chain_enable = r_chain_enable;
  assign chain_update = r_chain_update;

endmodule

// File: tb/tb_chain_driver.sv
// Bench for chain_driver with CELL_LEN=8, NUM_DEVICES=2. A behavioural model of two
// chained shift_register devices sits on the chain pins. Device bit_out and readback
// are checked against expectations derived from the written words.
`timescale 1ns/1ps

module tb_chain_driver;

  localparam int CL  = 8;
  localparam int ND  = 2;
  localparam int TOT = CL * ND;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [TOT-1:0] wr_data = '0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [TOT-1:0] rd_data;
  logic           rd_valid;
  logic           busy;
  logic           chain_data;
  logic           chain_enable;
  logic           chain_update;
  logic           chain_return;

  chain_driver #(.CELL_LEN(CL), .NUM_DEVICES(ND)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .chain_data   (chain_data),
    .chain_enable (chain_enable),
    .chain_update (chain_update),
    .chain_return (chain_return)
  );

  always #5 clk = ~clk;

  // Chain of two devices, indexed by position p: data enters at p=TOT-1, leaves at p=0.
  logic [TOT-1:0] chain_q = '0;
  logic [CL-1:0]  dev0_q = '0;
  logic [CL-1:0]  dev1_q = '0;
  assign chain_return = chain_q[0];

  always @(posedge clk) begin
    if (chain_enable) chain_q <= {chain_data, chain_q[TOT-1:1]};
    if (chain_update) begin
      dev0_q <= chain_q[TOT-1:CL];
      dev1_q <= chain_q[CL-1:0];
    end
  end

  // Protocol monitors.
  int  en_edges = 0;
  int  upd_edges = 0;
  int  glitch = 0;
  int  overlap = 0;
  int  rv_long = 0;
  bit  mon_on = 1'b0;
  logic rv_prev = 1'b0;

  always @(posedge clk) begin
    if (chain_enable === 1'b1) en_edges++;
    if (chain_update === 1'b1) upd_edges++;
    if (rd_valid === 1'b1 && rv_prev === 1'b1) rv_long++;
    rv_prev = rd_valid;
  end

  always @(chain_enable or chain_update or chain_data) begin
    if (mon_on && clk === 1'b1 && reset === 1'b0) glitch++;
  end

  always @(posedge clk or chain_enable or chain_update) begin
    if (chain_enable === 1'b1 && chain_update === 1'b1) overlap++;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transfer; returns the readback, the cycles waited before accept, and the latency.
  task automatic do_write(input logic [TOT-1:0] w, input bit toggle,
                          output logic [TOT-1:0] rd, output int waits, output int lat);
    int bad;
    wr_data  = w;
    wr_valid = 1'b1;
    waits    = 0;
    while (wr_ready !== 1'b1 && waits < 100) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("accept_timeout", {31'd0, wr_ready}, 32'd1);
    @(posedge clk); #1;  // E0
    wr_valid  = 1'b0;
    en_edges  = 0;
    upd_edges = 0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("ready_after_accept", {31'd0, wr_ready}, 32'd0);
    lat = 0;
    bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rd_valid === 1'b1) begin
        lat = i;
        break;
      end
      if (wr_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (toggle) begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_data  = TOT'($urandom);
      end
    end
    wr_valid = 1'b0;
    wr_data  = w;
    rd = rd_data;
    chk("latency", lat, TOT + 1);
    chk("ready_low_while_busy", bad, 0);
    chk("enable_edges", en_edges, TOT);
    chk("update_pulses", upd_edges, 1);
    chk("idle_ready", {30'd0, wr_ready, busy}, 32'd2);
  endtask

  typedef struct {
    logic [TOT-1:0] wr;
    logic [TOT-1:0] rd;
    logic [CL-1:0]  d0;
    logic [CL-1:0]  d1;
    bit             hold;
    bit             toggle;
  } vec_t;

  vec_t vecs[3];
  logic [TOT-1:0] rd;
  logic [TOT-1:0] prev;
  logic [TOT-1:0] part;
  logic [TOT-1:0] w;
  int waits;
  int lat;

  initial begin
    vecs[0] = '{wr: 16'hA55A, rd: 16'h0000, d0: 8'hA5, d1: 8'h5A, hold: 1'b0, toggle: 1'b0};
    vecs[1] = '{wr: 16'h1234, rd: 16'hA55A, d0: 8'h12, d1: 8'h34, hold: 1'b1, toggle: 1'b0};
    vecs[2] = '{wr: 16'h0F0F, rd: 16'h1234, d0: 8'h0F, d1: 8'h0F, hold: 1'b0, toggle: 1'b1};

    // Release reset, then assert it again mid-clock and check outputs before any edge.
    #27 reset = 1'b0;
    mon_on = 1'b1;
    #10 reset = 1'b1;
    #1;
    chk("reset_midclk_outputs",
        {rd_data, 9'd0, wr_ready, busy, rd_valid, chain_data, chain_enable, chain_update},
        {16'h0000, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven transfers.
    for (int v = 0; v < 3; v++) begin
      do_write(vecs[v].wr, vecs[v].toggle, rd, waits, lat);
      $display("[TB] write %h rd %h dev0 %h dev1 %h lat %0d wait %0d",
               vecs[v].wr, rd, dev0_q, dev1_q, lat, waits);
      chk("rd_data", rd, vecs[v].rd);
      chk("dev0", dev0_q, vecs[v].d0);
      chk("dev1", dev1_q, vecs[v].d1);
      if (vecs[v].hold) chk("back_to_back_accept", waits, 0);
    end

    // Reset in the middle of a shift: after E5, no update may follow.
    @(posedge clk); #1;
    wr_data = 16'h5555;
    wr_valid = 1'b1;
    @(posedge clk); #1;  // E0
    wr_valid = 1'b0;
    en_edges = 0;
    upd_edges = 0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("reset_midshift_outputs",
        {rd_data, 9'd0, wr_ready, busy, rd_valid, chain_data, chain_enable, chain_update},
        {16'h0000, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_enable_edges", en_edges, 5);
    chk("abort_no_update", upd_edges, 0);
    chk("abort_devices_kept", {dev0_q, dev1_q}, 16'h0F0F);
    $display("[TB] abort after 5 shifts dev0 %h dev1 %h", dev0_q, dev1_q);

    // Chain now holds 0F0F advanced by five bits of 5555.
    w = 16'h5555;
    part = (16'h0F0F >> 5) | (w << (TOT - 5));
    do_write(16'hFFFF, 1'b0, rd, waits, lat);
    $display("[TB] write %h rd %h dev0 %h dev1 %h lat %0d", 16'hFFFF, rd, dev0_q, dev1_q, lat);
    chk("rd_after_abort", rd, part);
    chk("dev0_ffff", dev0_q, 8'hFF);
    chk("dev1_ffff", dev1_q, 8'hFF);
    prev = 16'hFFFF;

    // Randomized transfers against a previous-word reference model.
    for (int n = 0; n < 10; n++) begin
      w = TOT'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_write(w, 1'($urandom_range(0, 1)), rd, waits, lat);
      $display("[TB] write %h rd %h dev0 %h dev1 %h lat %0d", w, rd, dev0_q, dev1_q, lat);
      chk("rand_rd", rd, prev);
      chk("rand_dev0", dev0_q, w[TOT-1:CL]);
      chk("rand_dev1", dev1_q, w[CL-1:0]);
      prev = w;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rd_valid_single_cycle", rv_long, 0);
    chk("chain_pins_change_on_low_clk", glitch, 0);
    chk("enable_update_exclusive", overlap, 0);
    chk("idle_chain_pins", {29'd0, chain_enable, chain_update, chain_data}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
